vx_alu_dotn: RTL and testbench
==============================

Name: vx_alu_dotn

Overview:
Parametrised packed dot-product processing element: the next generation of the ALU's fixed INT8 dot unit. Per lane, it multiplies packed sub-words of rs1 and rs2 and sums the products, with an optional accumulate from rs3. The element width is selectable per request (INT4/INT8/INT16), and the pipeline depth is configurable. It sits behind the ALU PE switch as one PE slot per ALU block, and adds a preemption drain handshake so the warp scheduler can quiesce the unit before context save.

Parameters:
NUM_LANES, 4, SIMD lanes processed per request
XLEN, 32, lane data width; 32 or 64 only
LATENCY, 3, pipeline stages from accept to result; 1..8
TAG_WIDTH, 8, opaque request tag (wid/PC/rd bundle index) carried to output

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_mode  in  2  0=INT8, 1=INT16, 2=INT4, 3=reserved
in_signed  in  1  1=signed elements, 0=unsigned
in_acc  in  1  1=add rs3 lane value to sum
in_rs1  in  NUM_LANES*XLEN  packed operand A, lane i at [i*XLEN +: XLEN]
in_rs2  in  NUM_LANES*XLEN  packed operand B
in_rs3  in  NUM_LANES*XLEN  accumulator input
in_tag  in  TAG_WIDTH  request tag
out_valid  out  1  result valid
out_ready  in  1  consumer ready
out_data  out  NUM_LANES*XLEN  per-lane result
out_tag  out  TAG_WIDTH  tag of the result
drain_req  in  1  preemption drain request, level-sensitive
drain_done  out  1  unit empty while drain requested
busy  out  1  any stage occupied

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits cleared; out_valid=0, drain_done=0, busy=0, occupancy counter=0. in_ready is combinational and is 1 after reset unless drain_req=1.
- Arithmetic, per lane: element width E = 8/16/4 for modes 0/1/2, N = XLEN/E elements. Element k occupies bits [k*E +: E]. Each element is sign- or zero-extended per in_signed. Sum of the N products, plus rs3 if in_acc, is truncated to XLEN (wrap modulo 2^XLEN). Mode 3 yields 0 for every lane and still consumes a slot and returns its tag.
- Pipeline: LATENCY stages, each holding valid, data and tag. Stage s advances when stage s+1 is empty or advancing; the last stage advances when out_ready. Bubbles collapse.
- in_ready = !drain_req && (stage0 empty || stage0 advancing).
- Latency: with out_ready held high, out_valid rises exactly LATENCY cycles after the accept edge. Full throughput is one request per cycle.
- Backpressure: out_valid, out_data and out_tag are held stable while out_valid && !out_ready. Upstream stages fill, then in_ready drops. Requests are never lost and never reordered.
- Occupancy counter (0..LATENCY): increments on accept, decrements on output handshake, unchanged on a simultaneous accept and output handshake. busy = (count != 0).
- Drain: while drain_req=1, no new accepts. In-flight requests complete normally. drain_done is registered and equals drain_req && count==0, so it asserts the cycle after the last output handshake. drain_done drops the cycle after drain_req deasserts.
- drain_req asserted in the same cycle as in_valid: the request is not accepted.
- A full pipe with out_ready=0 holds indefinitely; no overflow is possible.
- Reset mid-operation discards all in-flight requests; no output is emitted for them.

Test Plan:
- XLEN=32, mode 0 unsigned, rs1=0x01020304, rs2=0x05060708, in_acc=0 -> out_data lane=0x00000046 (70), out_valid exactly LATENCY cycles after accept, tag echoed.
- Mode 0, rs1=0xFFFFFFFF, rs2=0x01010101: signed -> 0xFFFFFFFC; unsigned -> 0x000003FC. Same mode, signed, with in_acc=1 and rs3=100 -> 0x00000060.
- Mode 1 signed, rs1=0x00020003, rs2=0x00040005 -> 0x00000017. Mode 2 unsigned, rs1=0x11111111, rs2=0x22222222 -> 0x00000010. Mode 3 -> 0 with tag returned.
- Back-to-back 10 requests with tags 0..9 while out_ready toggles 1,0,0,1 -> all 10 results in tag order, data stable while stalled, in_ready drops only when all LATENCY stages are full.
- 3 requests in flight, then drain_req=1 together with a new in_valid -> new request not accepted, 3 results emitted, drain_done=1 one cycle after the third handshake; drop drain_req -> drain_done=0 next cycle, new request accepted.
- Assert reset with 2 in flight and out_ready=0 -> out_valid, busy and drain_done go 0 immediately (asynchronously), no stale result after reset release.

Source files
------------

// File: rtl/vx_alu_dotn.sv
// vx_alu_dotn: packed dot-product processing element.
// Each lane multiplies the INT4/INT8/INT16 sub-words of rs1 and rs2 and adds
// up the products. It can also add the rs3 lane value. The result passes
// through a LATENCY-deep elastic pipeline with backpressure.
// A level-sensitive drain handshake stops new requests so the unit can empty
// before a context save.
module vx_alu_dotn #(
  parameter int NUM_LANES = 4,
  parameter int XLEN      = 32,
  parameter int LATENCY   = 3,
  parameter int TAG_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_mode,
  input  logic                          in_signed,
  input  logic                          in_acc,
  input  logic [NUM_LANES*XLEN-1:0]     in_rs1,
  input  logic [NUM_LANES*XLEN-1:0]     in_rs2,
  input  logic [NUM_LANES*XLEN-1:0]     in_rs3,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_LANES*XLEN-1:0]     out_data,
  output logic [TAG_WIDTH-1:0]          out_tag,
  input  logic                          drain_req,
  output logic                          drain_done,
  output logic                          busy
);

  localparam int DW = NUM_LANES * XLEN;
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    MODE_INT8  = 2'd0,
    MODE_INT16 = 2'd1,
    MODE_INT4  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // One lane: extend each element, multiply, and add up the products modulo 2^XLEN.
  // The products are truncated to XLEN bits, which is exact under wrap-around.
  function automatic logic [XLEN-1:0] lane_dot(
    input logic [1:0]      mode,
    input logic            sgn,
    input logic            acc,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic [XLEN-1:0] c
  );
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] ea;
    logic [XLEN-1:0] eb;
    sum = acc ? c : '0;
    ea  = '0;
    eb  = '0;
    case (mode)
      MODE_INT8: begin
        for (int k = 0; k < XLEN / 8; k++) begin
          ea  = {{(XLEN-8){sgn & a[k*8+7]}}, a[k*8 +: 8]};
          eb  = {{(XLEN-8){sgn & b[k*8+7]}}, b[k*8 +: 8]};
          sum = sum + ea * eb;
        end
      end
      MODE_INT16: begin
        for (int k = 0; k < XLEN / 16; k++) begin
          ea  = {{(XLEN-16){sgn & a[k*16+15]}}, a[k*16 +: 16]};
          eb  = {{(XLEN-16){sgn & b[k*16+15]}}, b[k*16 +: 16]};
          sum = sum + ea * eb;
        end
      end
      MODE_INT4: begin
        for (int k = 0; k < XLEN / 4; k++) begin
          ea  = {{(XLEN-4){sgn & a[k*4+3]}}, a[k*4 +: 4]};
          eb  = {{(XLEN-4){sgn & b[k*4+3]}}, b[k*4 +: 4]};
          sum = sum + ea * eb;
        end
      end
      default: sum = '0;  // reserved mode: zero result, slot and tag still flow
    endcase
    return sum;
  endfunction

  logic [DW-1:0]        dot_res;
  logic [LATENCY-1:0]   stg_valid;
  logic [LATENCY-1:0]   stg_ready;
  logic [DW-1:0]        stg_data [LATENCY];
  logic [TAG_WIDTH-1:0] stg_tag  [LATENCY];
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_nxt;
  logic                 accept;
  logic                 out_fire;

  // Per-lane dot products of the request currently presented.
  always_comb begin
    // NOTE: combinational blocks assign every output a default first, so no path leaves a value held (no latch).
    dot_res = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      dot_res[i*XLEN +: XLEN] = lane_dot(in_mode, in_signed, in_acc,
                                         in_rs1[i*XLEN +: XLEN],
                                         in_rs2[i*XLEN +: XLEN],
                                         in_rs3[i*XLEN +: XLEN]);
    end
  end

  // Ready chain: a stage can load if it is empty or if its content moves on this cycle.
  // This removes bubbles.
  always_comb begin
    // NOTE: blocking assignments here, because later iterations read stage bits that this loop has just computed.
    stg_ready = '0;
    stg_ready[LATENCY-1] = !stg_valid[LATENCY-1] || out_ready;
    for (int s = LATENCY - 2; s >= 0; s--) begin
      stg_ready[s] = !stg_valid[s] || stg_ready[s+1];
    end
  end

  assign in_ready = !drain_req && stg_ready[0];
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Stage valid bits: the only pipeline state that needs a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_valid <= '0;
    end else begin
      if (stg_ready[0]) stg_valid[0] <= accept;
      for (int s = 1; s < LATENCY; s++) begin
        if (stg_ready[s]) stg_valid[s] <= stg_valid[s-1];
      end
    end
  end

  // Stage payloads move only together with a valid entry. The last stage holds while it is stalled.
  // NOTE: data/tag registers are deliberately not reset; the valid bits alone decide whether they mean anything.
  always_ff @(posedge clk) begin
    if (stg_ready[0] && accept) begin
      stg_data[0] <= dot_res;
      stg_tag[0]  <= in_tag;
    end
    for (int s = 1; s < LATENCY; s++) begin
      if (stg_ready[s] && stg_valid[s-1]) begin
        stg_data[s] <= stg_data[s-1];
        stg_tag[s]  <= stg_tag[s-1];
      end
    end
  end

  // Occupancy: accept minus output handshake. The value is unchanged when both happen in the same cycle.
  always_comb begin
    count_nxt = count;
    case ({accept, out_fire})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Occupancy register and registered drain acknowledge.
  // The acknowledge uses the next count, so it rises in the cycle after the last handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      drain_done <= 1'b0;
    end else begin
      count      <= count_nxt;
      drain_done <= drain_req && (count_nxt == '0);
    end
  end

  assign busy      = (count != '0);
  assign out_valid = stg_valid[LATENCY-1];
  assign out_data  = stg_data[LATENCY-1];
  assign out_tag   = stg_tag[LATENCY-1];

endmodule

// File: tb/tb_vx_alu_dotn.sv
// Testbench for vx_alu_dotn: table vectors, back-to-back with backpressure,
// drain handshake, random traffic against a reference model, and reset mid-flight.
module tb_vx_alu_dotn;

  localparam int NL  = 4;
  localparam int XL  = 32;
  localparam int LAT = 3;
  localparam int TW  = 8;
  localparam int DW  = NL * XL;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic          in_signed;
  logic          in_acc;
  logic [DW-1:0] in_rs1;
  logic [DW-1:0] in_rs2;
  logic [DW-1:0] in_rs3;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          drain_req;
  logic          drain_done;
  logic          busy;

  vx_alu_dotn #(
    .NUM_LANES(NL), .XLEN(XL), .LATENCY(LAT), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_signed(in_signed), .in_acc(in_acc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .drain_req(drain_req), .drain_done(drain_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic        sgn;
    logic        acc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  int            errors = 0;
  int            checks = 0;
  int            n_out  = 0;
  logic          prev_drain = 1'b0;
  logic          stalled = 1'b0;
  logic [DW-1:0] held_data;
  logic [TW-1:0] held_tag;
  logic [DW-1:0] cur_exp;
  logic          last_accept;
  logic          last_out_valid;
  logic          last_in_ready;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a shift-and-mask extraction with signed 64-bit accumulation.
  function automatic logic [31:0] model(input logic [1:0] mode, input logic sgn,
                                        input logic acc, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c);
    int          e;
    longint      sa;
    longint      sb;
    longint      sum;
    logic [31:0] mask;
    logic [31:0] fa;
    logic [31:0] fb;
    if (mode == 2'd3) return 32'd0;
    e    = (mode == 2'd0) ? 8 : (mode == 2'd1) ? 16 : 4;
    mask = (32'd1 << e) - 32'd1;
    sum  = 0;
    for (int k = 0; k < 32 / e; k++) begin
      fa = (a >> (k * e)) & mask;
      fb = (b >> (k * e)) & mask;
      sa = longint'({32'd0, fa});
      sb = longint'({32'd0, fb});
      if (sgn && fa[e-1]) sa -= (longint'(1) << e);
      if (sgn && fb[e-1]) sb -= (longint'(1) << e);
      sum += sa * sb;
    end
    if (acc) sum += longint'({32'd0, c});
    return sum[31:0];
  endfunction

  // Drive a random request with independent lane values; the expected result comes from the model.
  task automatic rand_req(input logic [TW-1:0] tag);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    in_mode   = 2'($urandom_range(0, 3));
    in_signed = 1'($urandom_range(0, 1));
    in_acc    = 1'($urandom_range(0, 1));
    in_tag    = tag;
    for (int l = 0; l < NL; l++) begin
      a = $urandom;
      b = $urandom;
      c = $urandom;
      in_rs1[l*XL +: XL]  = a;
      in_rs2[l*XL +: XL]  = b;
      in_rs3[l*XL +: XL]  = c;
      cur_exp[l*XL +: XL] = model(in_mode, in_signed, in_acc, a, b, c);
    end
  endtask

  // One clock cycle. Inputs are stable at the falling edge, so sample there and score the
  // handshakes that the next rising edge will perform.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    last_accept    = in_valid && in_ready;
    last_out_valid = out_valid;
    last_in_ready  = in_ready;
    check("in_ready", in_ready, !drain_req && (sb_q.size() < LAT || out_ready));
    check("busy", busy, sb_q.size() != 0);
    check("drain_done", drain_done, prev_drain && sb_q.size() == 0);
    if (stalled) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, held_data);
      check("hold_tag", out_tag, held_tag);
    end
    stalled   = out_valid && !out_ready;
    held_data = out_data;
    held_tag  = out_tag;
    if (out_valid && out_ready) begin
      n_out++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: tag %h with no request outstanding", out_tag);
      end else begin
        e = sb_q.pop_front();
        check("out_tag", out_tag, e.tag);
        check("out_data", out_data, e.data);
      end
    end
    if (last_accept) sb_q.push_back('{in_tag, cur_exp});
    prev_drain = drain_req;
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 50) begin
      cycle();
      n++;
    end
    check("flush_empty", sb_q.size(), 0);
  endtask

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int sent;
    int cyc;
    logic saw_full;
    logic acc_during;
    logic [3:0] pat;

    tbl[0] = '{2'd0, 1'b0, 1'b0, 32'h01020304, 32'h05060708, 32'd0,        32'h00000046};
    tbl[1] = '{2'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h01010101, 32'd0,        32'hFFFFFFFC};
    tbl[2] = '{2'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h01010101, 32'd0,        32'h000003FC};
    tbl[3] = '{2'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h01010101, 32'd100,      32'h00000060};
    tbl[4] = '{2'd1, 1'b1, 1'b0, 32'h00020003, 32'h00040005, 32'd0,        32'h00000017};
    tbl[5] = '{2'd2, 1'b0, 1'b0, 32'h11111111, 32'h22222222, 32'd0,        32'h00000010};
    tbl[6] = '{2'd3, 1'b1, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'd55,       32'h00000000};
    tbl[7] = '{2'd1, 1'b1, 1'b0, 32'hFFFF0002, 32'h00030004, 32'd0,        32'h00000005};
    tbl[8] = '{2'd2, 1'b1, 1'b0, 32'h0000000F, 32'h00000007, 32'd0,        32'hFFFFFFF9};
    tbl[9] = '{2'd1, 1'b0, 1'b1, 32'hFFFF0000, 32'hFFFF0000, 32'h0001FFFF, 32'h00000000};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_signed = 1'b0;
    in_acc    = 1'b0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_rs3    = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    drain_req = 1'b0;
    cur_exp   = '0;

    // Reset state.
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_drain_done", drain_done, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    drain_req = 1'b1;
    #1;
    check("rst_in_ready_drain", in_ready, 1'b0);
    drain_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Table vectors, one at a time, with the latency measured for each.
    for (int i = 0; i < 10; i++) begin
      in_mode   = tbl[i].mode;
      in_signed = tbl[i].sgn;
      in_acc    = tbl[i].acc;
      in_rs1    = {NL{tbl[i].a}};
      in_rs2    = {NL{tbl[i].b}};
      in_rs3    = {NL{tbl[i].c}};
      in_tag    = TW'(8'h40 + i);
      cur_exp   = {NL{tbl[i].exp}};
      in_valid  = 1'b1;
      cycle();
      check("vec_accepted", last_accept, 1'b1);
      in_valid = 1'b0;
      lat = 0;
      do begin
        cycle();
        lat++;
      end while (!last_out_valid && lat < 20);
      check("vec_latency", lat, LAT);
    end

    // Back-to-back 10 requests while out_ready follows 1,0,0,1.
    pat      = 4'b1001;
    sent     = 0;
    cyc      = 0;
    n_out    = 0;
    saw_full = 1'b0;
    rand_req(TW'(0));
    while ((sent < 10 || sb_q.size() != 0) && cyc < 200) begin
      out_ready = pat[3 - (cyc % 4)];
      in_valid  = (sent < 10);
      cycle();
      if (in_valid && !last_in_ready) saw_full = 1'b1;
      if (last_accept) begin
        sent++;
        rand_req(TW'(sent));
      end
      cyc++;
    end
    check("b2b_done_in_time", cyc < 200, 1'b1);
    check("b2b_outputs", n_out, 10);
    check("b2b_saw_full", saw_full, 1'b1);
    flush();

    // Drain: 3 requests in flight, then drain_req together with a new request.
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      rand_req(TW'(8'h80 + t));
      in_valid = 1'b1;
      cycle();
      check("drain_pre_accept", last_accept, 1'b1);
    end
    rand_req(TW'(8'h90));
    in_valid   = 1'b1;
    drain_req  = 1'b1;
    n_out      = 0;
    acc_during = 1'b0;
    cyc        = 0;
    while (sb_q.size() != 0 && cyc < 20) begin
      cycle();
      if (last_accept) acc_during = 1'b1;
      cyc++;
    end
    check("drain_no_accept", acc_during, 1'b0);
    check("drain_outputs", n_out, 3);
    check("drain_done_set", drain_done, 1'b1);
    drain_req = 1'b0;
    cycle();
    check("drain_release_accept", last_accept, 1'b1);
    check("drain_done_clear", drain_done, 1'b0);
    flush();

    // Random traffic with random valid and random backpressure.
    sent = 0;
    cyc  = 0;
    rand_req(TW'(8'hA0));
    while (sent < 40 && cyc < 2000) begin
      if (!in_valid || $urandom_range(0, 3) != 0) in_valid = 1'b1;
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
      if (last_accept) begin
        sent++;
        rand_req(TW'(8'hA0 + sent));
        in_valid = 1'(($urandom_range(0, 4) != 0));
      end
      cyc++;
    end
    check("rand_sent", sent, 40);
    flush();

    // Reset with 2 in flight and out_ready low.
    out_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      rand_req(TW'(8'hE0 + t));
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("pre_reset_valid", out_valid, 1'b1);
    check("pre_reset_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_drain_done", drain_done, 1'b0);
    sb_q.delete();
    prev_drain = 1'b0;
    stalled    = 1'b0;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    n_out     = 0;
    repeat (8) cycle();
    check("no_stale_output", n_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
